imm_gen_pipe: RTL and testbench

- Registered, XLEN-parametrised immediate generator for the decode stage, with a valid/ready handshake on both sides.
- Extracts and sign-extends the I/S/B/U/J immediate and computes the PC-relative target (pc + imm) in the same stage.
- A two-entry skid buffer sustains full throughput under downstream backpressure.
- Feeds the execute stage and the branch unit, and carries a sideband tag alongside each entry.

---
 rtl/imm_gen_pipe.sv | 166 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with PC-relative target and skid buffer
//
// Purpose:
//   Decode-stage helper that extracts the I/S/B/U/J immediate from an
//   instruction word, sign-extends it to XLEN and adds it to the PC. Results
//   are registered behind a valid/ready handshake, and a two-entry skid buffer
//   allows one accept per cycle under downstream backpressure.
//
// Optional feature:
//   IMM_GEN_ZICSR_EN - when defined, fmt_i=5 selects the CSR zimm
//   (zero-extended instr[19:15]). When undefined, fmt_i=5 is illegal.
//
// Ports:
//   clk_i     clock
//   rst_ni    synchronous active-low reset
//   flush_i   drop every buffered entry (and any entry offered in that cycle)
//   valid_i   upstream entry valid
//   ready_o   block can accept (registered, low only when both entries full)
//   instr_i   raw 32-bit instruction word
//   fmt_i     0=I 1=S 2=B 3=U 4=J 5=Z(optional), others illegal
//   pc_i      instruction address
//   tag_i     opaque sideband tag
//   valid_o   output entry valid
//   ready_i   downstream accepts the output entry
//   imm_o     extended immediate
//   target_o  pc + imm_o modulo 2^XLEN
//   err_o     entry carried an illegal fmt_i
//   tag_o     tag of the output entry

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       fmt_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [XLEN-1:0]  target_o,
  output logic             err_o,
  output logic [TAG_W-1:0] tag_o
);

  // One buffer entry: {imm, target, err, tag}
  localparam int EW = 2 * XLEN + 1 + TAG_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MAIN  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_valid;
  logic               r_ready;
  logic [EW-1:0]      r_out;
  logic [EW-1:0]      r_skid;

  logic signed [31:0] w_imm32;
  logic               w_err;
  logic [XLEN-1:0]    w_imm;
  logic [XLEN-1:0]    w_target;
  logic [EW-1:0]      w_entry;
  logic               w_accept;
  logic               w_retire;

  // The opcode field never contributes to any immediate.
  logic               w_unused_opcode;
  assign w_unused_opcode = ^instr_i[6:0];

  // Every format is built as a 32-bit value whose bit 31 is the sign, so one
  // sign-extending cast covers XLEN=64 (including U sign-extended from bit 31).
  // The Z immediate has bit 31 clear, so the same cast zero-extends it.
  always_comb begin
    w_imm32 = '0;
    w_err   = 1'b0;
    case (fmt_i)
      3'd0: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      3'd1: w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'd2: w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
      3'd3: w_imm32 = {instr_i[31:12], 12'h000};
      3'd4: w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
      3'd5: w_imm32 = {27'd0, instr_i[19:15]};
`endif
      default: begin
        // Illegal format: zero immediate so the target collapses to pc.
        w_imm32 = '0;
        w_err   = 1'b1;
      end
    endcase
  end

  assign w_imm    = XLEN'(w_imm32);
  assign w_target = pc_i + w_imm;
  assign w_entry  = {w_imm, w_target, w_err, tag_i};

  assign w_accept = valid_i && r_ready;
  assign w_retire = r_valid && ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_out   <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      // Flush wins over accept and retire; stale data may remain in r_out,
      // hidden behind valid_o=0.
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_ready <= 1'b1;
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_out   <= w_entry;
            r_valid <= 1'b1;
            r_state <= S_MAIN;
          end
        end
        S_MAIN: begin
          if (w_accept && w_retire) begin
            r_out <= w_entry;
          end else if (w_accept) begin
            r_skid  <= w_entry;
            r_state <= S_SKID;
            r_ready <= 1'b0;
          end else if (w_retire) begin
            r_valid <= 1'b0;
            r_state <= S_EMPTY;
          end
        end
        S_SKID: begin
          // r_ready is low here, so no accept can arrive in this state.
          if (w_retire) begin
            r_out   <= r_skid;
            r_state <= S_MAIN;
          end else begin
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign valid_o = r_valid;
  assign ready_o = r_ready;
  assign {imm_o, target_o, err_o, tag_o} = r_out;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64
//
// Both instances share all inputs (dut32 sees the low half of pc), so their
// handshake behaviour is identical and one FIFO reference model serves both.

module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [2:0]  fmt_i;
  logic [63:0] pc_i;
  logic [7:0]  tag_i;
  logic        ready_i;

  logic        ready32, valid32, err32;
  logic [31:0] imm32, tgt32;
  logic [7:0]  tag32;
  logic        ready64, valid64, err64;
  logic [63:0] imm64, tgt64;
  logic [7:0]  tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready32),
    .instr_i(instr_i), .fmt_i(fmt_i), .pc_i(pc_i[31:0]), .tag_i(tag_i),
    .valid_o(valid32), .ready_i(ready_i),
    .imm_o(imm32), .target_o(tgt32), .err_o(err32), .tag_o(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready64),
    .instr_i(instr_i), .fmt_i(fmt_i), .pc_i(pc_i), .tag_i(tag_i),
    .valid_o(valid64), .ready_i(ready_i),
    .imm_o(imm64), .target_o(tgt64), .err_o(err64), .tag_o(tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        err;
    logic [7:0]  tag;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic        err;
  } vec_t;

  int   checks;
  int   failures;
  ent_t q[$];
  bit   m_rstd;
  logic [7:0] got_tags[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Immediate as a signed number, computed from the field layout with plain
  // arithmetic, then wrapped to 64 bits.
  function automatic ent_t ref_ent(input logic [31:0] ins, input logic [2:0] f,
                                   input logic [63:0] p, input logic [7:0] t);
    ent_t   e;
    longint v;
    logic   bad;
    v   = 0;
    bad = 1'b0;
    case (f)
      3'd0: begin v = longint'(ins[31:20]); if (ins[31]) v -= 4096; end
      3'd1: begin v = longint'({ins[31:25], ins[11:7]}); if (ins[31]) v -= 4096; end
      3'd2: begin
        v = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        if (ins[31]) v -= 8192;
      end
      3'd3: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= 64'sh1_0000_0000; end
      3'd4: begin
        v = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        if (ins[31]) v -= 2097152;
      end
`ifdef IMM_GEN_ZICSR_EN
      3'd5: v = longint'(ins[19:15]);
`endif
      default: bad = 1'b1;
    endcase
    e.imm = 64'(v);
    e.tgt = p + 64'(v);
    e.err = bad;
    e.tag = t;
    return e;
  endfunction

  task automatic check_outputs();
    if (m_rstd) begin
      chk("rst_valid32", valid32, 0); chk("rst_valid64", valid64, 0);
      chk("rst_ready32", ready32, 0); chk("rst_ready64", ready64, 0);
      chk("rst_imm32", imm32, 0);     chk("rst_imm64", imm64, 0);
      chk("rst_tgt32", tgt32, 0);     chk("rst_tgt64", tgt64, 0);
      chk("rst_err32", err32, 0);     chk("rst_err64", err64, 0);
      chk("rst_tag32", tag32, 0);     chk("rst_tag64", tag64, 0);
    end else begin
      chk("valid32", valid32, 64'(q.size() > 0));
      chk("valid64", valid64, 64'(q.size() > 0));
      chk("ready32", ready32, 64'(q.size() < 2));
      chk("ready64", ready64, 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("imm32", imm32, {32'd0, q[0].imm[31:0]});
        chk("tgt32", tgt32, {32'd0, q[0].tgt[31:0]});
        chk("err32", err32, 64'(q[0].err));
        chk("tag32", tag32, 64'(q[0].tag));
        chk("imm64", imm64, q[0].imm);
        chk("tgt64", tgt64, q[0].tgt);
        chk("err64", err64, 64'(q[0].err));
        chk("tag64", tag64, 64'(q[0].tag));
      end
    end
  endtask

  // Called just after a falling edge: drive, advance one clock, update the
  // FIFO model, then check on the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] f,
                       input logic [63:0] p, input logic [7:0] t, input logic rdy,
                       input logic fl, input logic rst);
    bit acc, ret;
    valid_i = v; instr_i = ins; fmt_i = f; pc_i = p; tag_i = t;
    ready_i = rdy; flush_i = fl; rst_ni = rst;
    acc = v && !m_rstd && (q.size() < 2);
    ret = rdy && !m_rstd && (q.size() > 0);
    if (ret && rst && !fl) got_tags.push_back(tag64);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_rstd = 1'b1;
    end else begin
      m_rstd = 1'b0;
      if (fl) q.delete();
      else begin
        if (ret) void'(q.pop_front());
        if (acc) q.push_back(ref_ent(ins, f, p, t));
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 3'd0, 64'h0, 8'h0, rdy, 1'b0, 1'b1);
  endtask

  vec_t tbl[8];

  initial begin
    checks   = 0;
    failures = 0;
    m_rstd   = 1'b1;

    tbl[0] = '{32'hFFF00093, 3'd0, 64'h0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1] = '{32'hFE000EE3, 3'd2, 64'h100,
               32'hFFFFFFFC, 32'h000000FC, 64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 1'b0};
    tbl[2] = '{32'h80000037, 3'd3, 64'h0,
               32'h80000000, 32'h80000000, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl[3] = '{32'h02000093, 3'd0, 64'hFFFFFFFFFFFFFFF0,
               32'h00000020, 32'h00000010, 64'h20, 64'h10, 1'b0};
    tbl[4] = '{32'h12345678, 3'd7, 64'h40,
               32'h0, 32'h40, 64'h0, 64'h40, 1'b1};
`ifdef IMM_GEN_ZICSR_EN
    tbl[5] = '{32'h000F8000, 3'd5, 64'h8,
               32'h1F, 32'h27, 64'h1F, 64'h27, 1'b0};
`else
    tbl[5] = '{32'h000F8000, 3'd5, 64'h8,
               32'h0, 32'h8, 64'h0, 64'h8, 1'b1};
`endif
    tbl[6] = '{32'h00A12223, 3'd1, 64'h1000,
               32'h4, 32'h1004, 64'h4, 64'h1004, 1'b0};
    tbl[7] = '{32'h0080006F, 3'd4, 64'h2000,
               32'h8, 32'h2008, 64'h8, 64'h2008, 1'b0};

    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    instr_i = '0; fmt_i = '0; pc_i = '0; tag_i = '0;
    @(negedge clk);

    // Reset, then release: ready must rise one edge after release.
    cycle(1'b0, 32'h0, 3'd0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 3'd0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Table vectors, back to back with ready_i high.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].instr, tbl[i].fmt, tbl[i].pc, 8'(i), 1'b1, 1'b0, 1'b1);
      chk("tbl_imm32", imm32, {32'd0, tbl[i].imm32});
      chk("tbl_tgt32", tgt32, {32'd0, tbl[i].tgt32});
      chk("tbl_imm64", imm64, tbl[i].imm64);
      chk("tbl_tgt64", tgt64, tbl[i].tgt64);
      chk("tbl_err64", err64, 64'(tbl[i].err));
      chk("tbl_err32", err32, 64'(tbl[i].err));
    end
    idle(1'b1);

    // Backpressure: tags 1,2,3 with ready_i low; tag 3 must stall.
    got_tags.delete();
    cycle(1'b1, 32'h00100093, 3'd0, 64'h10, 8'd1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00200093, 3'd0, 64'h20, 8'd2, 1'b0, 1'b0, 1'b1);
    chk("bp_ready_low", ready64, 0);
    cycle(1'b1, 32'h00300093, 3'd0, 64'h30, 8'd3, 1'b0, 1'b0, 1'b1);
    chk("bp_stall_tag", tag64, 8'd1);
    cycle(1'b1, 32'h00300093, 3'd0, 64'h30, 8'd3, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h00300093, 3'd0, 64'h30, 8'd3, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("bp_count", 64'(got_tags.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_tags.size()) chk("bp_order", got_tags[i], 64'(i + 1));
    end

    // Flush while in SKID together with a new valid entry.
    cycle(1'b1, 32'h00400093, 3'd0, 64'h0, 8'd4, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00500093, 3'd0, 64'h0, 8'd5, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00600093, 3'd0, 64'h0, 8'd6, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", valid64, 0);
    chk("flush_ready", ready64, 1);
    idle(1'b1);
    idle(1'b1);
    chk("flush_gone", valid64, 0);

    // Reset mid-stream.
    cycle(1'b1, 32'h00700093, 3'd0, 64'h0, 8'd7, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00800093, 3'd0, 64'h0, 8'd8, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00900093, 3'd0, 64'h0, 8'd9, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("rst_mid_empty", valid64, 0);

    // Randomised traffic against the FIFO model.
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
            {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 29) == 0), 1'b1);
    end
    for (int n = 0; n < 4; n++) idle(1'b1);
    chk("final_empty", valid64, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
